// File: rtl/cpu_bus_sequencer.sv
// One-hot step sequencer and bus source mux for the 7-step CPU; enables are same-cycle, qualified by advance.
// RAM/IO not-ready stalls the step in place; optional early return to step 1 under CPU_BUS_STEP_SKIP_EN.
module cpu_bus_sequencer #(
  parameter int DATA_W = 8,
  parameter int GPR_N  = 4,
  parameter int STEPS  = 6,
  localparam int RW    = (GPR_N > 2) ? $clog2(GPR_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_ir,
  input  logic              i_flags_hit,
  input  logic              i_ram_ready,
  input  logic              i_io_ready,
  input  logic [DATA_W-1:0] i_gpr_a,
  input  logic [DATA_W-1:0] i_gpr_b,
  input  logic [DATA_W-1:0] i_ram,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_iar,
  input  logic [DATA_W-1:0] i_io,
  output logic [RW-1:0]     o_gpr_a_sel,
  output logic [RW-1:0]     o_gpr_b_sel,
  output logic [RW-1:0]     o_gpr_wsel,
  output logic [STEPS-1:0]  o_step,
  output logic [DATA_W-1:0] o_bus,
  output logic              o_ir_we,
  output logic              o_iar_we,
  output logic              o_mar_we,
  output logic              o_tmp_we,
  output logic              o_acc_we,
  output logic              o_gpr_we,
  output logic              o_ram_we,
  output logic              o_io_we,
  output logic              o_bus1,
  output logic              o_alu_go,
  output logic              o_instr_done
);

  localparam logic [3:0] OP_LD    = 4'b0000;
  localparam logic [3:0] OP_ST    = 4'b0001;
  localparam logic [3:0] OP_DATA  = 4'b0010;
  localparam logic [3:0] OP_JMPR  = 4'b0011;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_JMPIF = 4'b0101;
  localparam logic [3:0] OP_CLF   = 4'b0110;
  localparam logic [3:0] OP_IO    = 4'b0111;
  localparam logic [3:0] OP_CMP   = 4'b1111;
  localparam logic [STEPS-1:0] STEP_FIRST = {{(STEPS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    SRC_NONE, SRC_A, SRC_B, SRC_RAM, SRC_ACC, SRC_IAR, SRC_IO
  } src_e;

  logic [STEPS-1:0] step_q, step_d, last_mask;
  logic [3:0]       opcode;
  logic             io_out, is_alu, adv, is_last, wait_c;
  logic             ir_we_c, iar_we_c, mar_we_c, tmp_we_c, acc_we_c, gpr_we_c, ram_we_c, io_we_c;
  logic             bus1_c, alu_c;
  src_e             src;
  logic [DATA_W-1:0] bus_mux;
  logic             ir_unused;

  assign opcode    = i_ir[DATA_W-1 -: 4];
  assign io_out    = i_ir[DATA_W-5];
  assign is_alu    = opcode[3];
  assign ir_unused = ^i_ir;

  assign o_gpr_a_sel = i_ir[2*RW-1:RW];
  assign o_gpr_b_sel = i_ir[RW-1:0];
  assign o_gpr_wsel  = i_ir[RW-1:0];
  assign o_step      = step_q;

  always_ff @(posedge clk) begin
    if (!rst_n) step_q <= STEP_FIRST;
    else        step_q <= step_d;
  end

  // Per-step transfer decode; enables here are raw and get qualified by adv below.
  always_comb begin
    src = SRC_NONE;
    {ir_we_c, iar_we_c, mar_we_c, tmp_we_c, acc_we_c, gpr_we_c, ram_we_c, io_we_c} = '0;
    bus1_c = 1'b0;
    alu_c  = 1'b0;
    wait_c = 1'b0;
    if (step_q[0]) begin
      src = SRC_IAR; mar_we_c = 1'b1; bus1_c = 1'b1; acc_we_c = 1'b1;
    end else if (step_q[1]) begin
      src = SRC_RAM; ir_we_c = 1'b1; wait_c = ~i_ram_ready;
    end else if (step_q[2]) begin
      src = SRC_ACC; iar_we_c = 1'b1;
    end else if (step_q[3]) begin
      if (is_alu) begin
        src = SRC_B; tmp_we_c = 1'b1;
      end else begin
        case (opcode)
          OP_LD, OP_ST: begin src = SRC_A; mar_we_c = 1'b1; end
          OP_DATA, OP_JMPIF: begin
            src = SRC_IAR; mar_we_c = 1'b1; bus1_c = 1'b1; acc_we_c = 1'b1;
          end
          OP_JMPR: begin src = SRC_B; iar_we_c = 1'b1; end
          OP_JMP:  begin src = SRC_IAR; mar_we_c = 1'b1; end
          OP_IO: begin
            wait_c = ~i_io_ready;
            if (io_out) begin src = SRC_B;  io_we_c  = 1'b1; end
            else        begin src = SRC_IO; gpr_we_c = 1'b1; end
          end
          default: ;
        endcase
      end
    end else if (step_q[4]) begin
      if (is_alu) begin
        src = SRC_A; alu_c = 1'b1; acc_we_c = 1'b1;
      end else begin
        case (opcode)
          OP_LD, OP_DATA: begin src = SRC_RAM; gpr_we_c = 1'b1; wait_c = ~i_ram_ready; end
          OP_ST:    begin src = SRC_B;   ram_we_c = 1'b1; end
          OP_JMP:   begin src = SRC_RAM; iar_we_c = 1'b1; wait_c = ~i_ram_ready; end
          OP_JMPIF: begin src = SRC_ACC; iar_we_c = 1'b1; end
          default: ;
        endcase
      end
    end else if (step_q[5]) begin
      if (is_alu) begin
        src = SRC_ACC; gpr_we_c = (opcode != OP_CMP);
      end else if (opcode == OP_DATA) begin
        src = SRC_ACC; iar_we_c = 1'b1;
      end else if (opcode == OP_JMPIF && i_flags_hit) begin
        src = SRC_RAM; iar_we_c = 1'b1; wait_c = ~i_ram_ready;
      end
    end
  end

  always_comb begin
    last_mask = '0;
    last_mask[STEPS-1] = 1'b1;
`ifdef CPU_BUS_STEP_SKIP_EN
    case (opcode)
      OP_JMPR, OP_IO:       begin last_mask = '0; last_mask[3] = 1'b1; end
      OP_LD, OP_ST, OP_JMP: begin last_mask = '0; last_mask[4] = 1'b1; end
      OP_CLF:               begin last_mask = '0; last_mask[2] = 1'b1; end
      OP_JMPIF: if (!i_flags_hit) begin last_mask = '0; last_mask[4] = 1'b1; end
      default: ;
    endcase
`endif
  end

  assign adv     = rst_n & i_run & ~wait_c;
  assign is_last = |(step_q & last_mask);

  always_comb begin
    step_d = step_q;
    if (adv) step_d = is_last ? STEP_FIRST : {step_q[STEPS-2:0], step_q[STEPS-1]};
  end

  always_comb begin
    bus_mux = '0;
    case (src)
      SRC_A:   bus_mux = i_gpr_a;
      SRC_B:   bus_mux = i_gpr_b;
      SRC_RAM: bus_mux = i_ram;
      SRC_ACC: bus_mux = i_acc;
      SRC_IAR: bus_mux = i_iar;
      SRC_IO:  bus_mux = i_io;
      default: bus_mux = '0;
    endcase
    o_bus        = i_run ? bus_mux : '0;
    o_bus1       = i_run & bus1_c;
    o_ir_we      = adv & ir_we_c;
    o_iar_we     = adv & iar_we_c;
    o_mar_we     = adv & mar_we_c;
    o_tmp_we     = adv & tmp_we_c;
    o_acc_we     = adv & acc_we_c;
    o_gpr_we     = adv & gpr_we_c;
    o_ram_we     = adv & ram_we_c;
    o_io_we      = adv & io_we_c;
    o_alu_go     = adv & alu_c;
    o_instr_done = adv & is_last;
  end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Randomized and directed bench for cpu_bus_sequencer against a step-number reference model.
module tb_cpu_bus_sequencer;
  localparam int DW = 8;
  localparam int GN = 4;
  localparam int ST = 6;
  localparam int RW = 2;

  localparam logic [7:0] W_IR = 8'h01, W_IAR = 8'h02, W_MAR = 8'h04, W_TMP = 8'h08;
  localparam logic [7:0] W_ACC = 8'h10, W_GPR = 8'h20, W_RAM = 8'h40, W_IO = 8'h80;

  logic clk = 1'b0;
  logic rst_n, i_run, i_flags_hit, i_ram_ready, i_io_ready;
  logic [DW-1:0] i_ir, i_gpr_a, i_gpr_b, i_ram, i_acc, i_iar, i_io;
  logic [RW-1:0] o_gpr_a_sel, o_gpr_b_sel, o_gpr_wsel;
  logic [ST-1:0] o_step;
  logic [DW-1:0] o_bus;
  logic o_ir_we, o_iar_we, o_mar_we, o_tmp_we, o_acc_we, o_gpr_we, o_ram_we, o_io_we;
  logic o_bus1, o_alu_go, o_instr_done;

  always #5 clk = ~clk;

  cpu_bus_sequencer #(.DATA_W(DW), .GPR_N(GN), .STEPS(ST)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_ir(i_ir), .i_flags_hit(i_flags_hit),
    .i_ram_ready(i_ram_ready), .i_io_ready(i_io_ready),
    .i_gpr_a(i_gpr_a), .i_gpr_b(i_gpr_b), .i_ram(i_ram), .i_acc(i_acc), .i_iar(i_iar), .i_io(i_io),
    .o_gpr_a_sel(o_gpr_a_sel), .o_gpr_b_sel(o_gpr_b_sel), .o_gpr_wsel(o_gpr_wsel),
    .o_step(o_step), .o_bus(o_bus),
    .o_ir_we(o_ir_we), .o_iar_we(o_iar_we), .o_mar_we(o_mar_we), .o_tmp_we(o_tmp_we),
    .o_acc_we(o_acc_we), .o_gpr_we(o_gpr_we), .o_ram_we(o_ram_we), .o_io_we(o_io_we),
    .o_bus1(o_bus1), .o_alu_go(o_alu_go), .o_instr_done(o_instr_done)
  );

  int n_chk = 0;
  int n_fail = 0;
  int m_step, m_next;
  logic [7:0] e_we;
  logic [DW-1:0] e_bus;
  logic e_bus1, e_alu, e_done, e_adv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d, ir 0x%0h)", tag, got, exp, m_step, i_ir);
    end
  endtask

  function automatic logic [7:0] dut_we();
    return {o_io_we, o_ram_we, o_gpr_we, o_acc_we, o_tmp_we, o_mar_we, o_iar_we, o_ir_we};
  endfunction

  // Reference: transfer table indexed by step number and opcode name.
  task automatic model_eval();
    int op, src, last;
    logic [7:0] dst;
    logic b1, alu, wt, io_out;
    op = int'(i_ir[7:4]);
    io_out = i_ir[3];
    src = 0; dst = 8'h00; b1 = 1'b0; alu = 1'b0; wt = 1'b0; last = ST;
    case (m_step)
      1: begin src = 5; dst = W_MAR | W_ACC; b1 = 1'b1; end
      2: begin src = 3; dst = W_IR; wt = !i_ram_ready; end
      3: begin src = 4; dst = W_IAR; end
      4: begin
        if (op >= 8) begin src = 2; dst = W_TMP; end
        else case (op)
          0, 1: begin src = 1; dst = W_MAR; end
          2, 5: begin src = 5; dst = W_MAR | W_ACC; b1 = 1'b1; end
          3: begin src = 2; dst = W_IAR; end
          4: begin src = 5; dst = W_MAR; end
          7: begin wt = !i_io_ready; if (io_out) begin src = 2; dst = W_IO; end else begin src = 6; dst = W_GPR; end end
          default: ;
        endcase
      end
      5: begin
        if (op >= 8) begin src = 1; dst = W_ACC; alu = 1'b1; end
        else case (op)
          0, 2: begin src = 3; dst = W_GPR; wt = !i_ram_ready; end
          1: begin src = 2; dst = W_RAM; end
          4: begin src = 3; dst = W_IAR; wt = !i_ram_ready; end
          5: begin src = 4; dst = W_IAR; end
          default: ;
        endcase
      end
      6: begin
        if (op >= 8) begin src = 4; dst = (op == 15) ? 8'h00 : W_GPR; end
        else if (op == 2) begin src = 4; dst = W_IAR; end
        else if (op == 5 && i_flags_hit) begin src = 3; dst = W_IAR; wt = !i_ram_ready; end
      end
      default: ;
    endcase
`ifdef CPU_BUS_STEP_SKIP_EN
    if (op == 3 || op == 7) last = 4;
    else if (op == 0 || op == 1 || op == 4) last = 5;
    else if (op == 6) last = 3;
    else if (op == 5 && !i_flags_hit) last = 5;
`endif
    e_adv  = rst_n && i_run && !wt;
    e_we   = e_adv ? dst : 8'h00;
    e_alu  = e_adv && alu;
    e_bus1 = i_run && b1;
    e_done = e_adv && (m_step == last);
    case (src)
      1: e_bus = i_gpr_a;
      2: e_bus = i_gpr_b;
      3: e_bus = i_ram;
      4: e_bus = i_acc;
      5: e_bus = i_iar;
      6: e_bus = i_io;
      default: e_bus = '0;
    endcase
    if (!i_run) e_bus = '0;
    if (!rst_n) m_next = 1;
    else if (e_adv) m_next = (m_step == last) ? 1 : m_step + 1;
    else m_next = m_step;
  endtask

  task automatic settle();
    #1;
    model_eval();
    chk("step", 32'(o_step), 32'(1) << (m_step - 1));
    chk("bus", 32'(o_bus), 32'(e_bus));
    chk("we", 32'(dut_we()), 32'(e_we));
    chk("bus1", 32'(o_bus1), 32'(e_bus1));
    chk("alu_go", 32'(o_alu_go), 32'(e_alu));
    chk("instr_done", 32'(o_instr_done), 32'(e_done));
    chk("a_sel", 32'(o_gpr_a_sel), 32'(i_ir[3:2]));
    chk("b_sel", 32'(o_gpr_b_sel), 32'(i_ir[1:0]));
    chk("wsel", 32'(o_gpr_wsel), 32'(i_ir[1:0]));
  endtask

  task automatic adv_clk();
    @(posedge clk);
    m_step = m_next;
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    adv_clk();
  endtask

  task automatic run_to(input int s);
    int n;
    n = 0;
    while (m_step != s && n < 40) begin
      tick();
      n++;
    end
    if (m_step != s) chk("run_to_timeout", 32'(m_step), 32'(s));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; i_run = 1'b1; i_ir = 8'h86; i_flags_hit = 1'b0;
    i_ram_ready = 1'b1; i_io_ready = 1'b1;
    i_gpr_a = 8'h12; i_gpr_b = 8'h21; i_ram = 8'haa; i_acc = 8'h66; i_iar = 8'h55; i_io = 8'h99;
    m_step = 1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset held two clocks
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("rst_step", 32'(o_step), 32'h01);
      chk("rst_we", 32'(dut_we()), 32'h0);
      chk("rst_done", 32'(o_instr_done), 32'h0);
      adv_clk();
    end
    rst_n = 1'b1;

    // ADD fetch and execute
    settle(); chk("add_s1_bus", 32'(o_bus), 32'h55); chk("add_s1_we", 32'(dut_we()), 32'(W_MAR | W_ACC));
    chk("add_s1_bus1", 32'(o_bus1), 32'h1); adv_clk();
    settle(); chk("add_s2_bus", 32'(o_bus), 32'haa); chk("add_s2_we", 32'(dut_we()), 32'(W_IR)); adv_clk();
    tick();
    settle(); chk("add_s4_bus", 32'(o_bus), 32'h21); chk("add_s4_we", 32'(dut_we()), 32'(W_TMP)); adv_clk();
    tick();
    settle(); chk("add_s6_gpr_we", 32'(o_gpr_we), 32'h1); chk("add_s6_wsel", 32'(o_gpr_wsel), 32'h2);
    chk("add_s6_done", 32'(o_instr_done), 32'h1); adv_clk();

    // CMP suppresses the write-back
    i_ir = 8'hF6;
    run_to(6);
    settle(); chk("cmp_s6_gpr_we", 32'(o_gpr_we), 32'h0); adv_clk();

    // LD with RAM not ready for three cycles in step 5
    i_ir = 8'h06; i_ram = 8'h4d;
    run_to(5);
    i_ram_ready = 1'b0; pulses = 0;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("ld_wait_bus", 32'(o_bus), 32'h4d); chk("ld_wait_step", 32'(o_step), 32'h10);
      pulses += int'(o_gpr_we); adv_clk();
    end
    i_ram_ready = 1'b1;
    settle(); pulses += int'(o_gpr_we); adv_clk();
    chk("ld_gpr_pulses", 32'(pulses), 32'h1);

    // JMPIF not taken, then taken
    i_ir = 8'h50; i_flags_hit = 1'b0;
    run_to(6);
    settle(); chk("jmpif_nt_iar_we", 32'(o_iar_we), 32'h0); adv_clk();
    i_flags_hit = 1'b1; i_ram = 8'h3c;
    run_to(6);
    settle(); chk("jmpif_t_bus", 32'(o_bus), 32'h3c); chk("jmpif_t_iar_we", 32'(o_iar_we), 32'h1); adv_clk();
    i_flags_hit = 1'b0;

    // IO out with device stall, then IO in
    i_ir = 8'h7B; i_gpr_b = 8'hff;
    run_to(4);
    i_io_ready = 1'b0; pulses = 0;
    for (int k = 0; k < 2; k++) begin
      settle(); chk("io_out_bus", 32'(o_bus), 32'hff); pulses += int'(o_io_we); adv_clk();
    end
    i_io_ready = 1'b1;
    settle(); pulses += int'(o_io_we); adv_clk();
    chk("io_we_pulses", 32'(pulses), 32'h1);
    i_ir = 8'h73; i_io = 8'hdd;
    run_to(4);
    settle(); chk("io_in_gpr_we", 32'(o_gpr_we), 32'h1); chk("io_in_bus", 32'(o_bus), 32'hdd); adv_clk();

    // Reset in step 5 of ST
    i_ir = 8'h16;
    run_to(5);
    rst_n = 1'b0;
    settle(); chk("st_rst_ram_we", 32'(o_ram_we), 32'h0); adv_clk();
    rst_n = 1'b1;
    settle(); chk("st_rst_step", 32'(o_step), 32'h01); adv_clk();

`ifdef CPU_BUS_STEP_SKIP_EN
    i_ir = 8'h36;
    run_to(4);
    settle(); chk("jmpr_skip_done", 32'(o_instr_done), 32'h1); adv_clk();
    settle(); chk("jmpr_skip_step", 32'(o_step), 32'h01); adv_clk();
`endif

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      i_ir        = 8'($urandom);
      i_run       = ($urandom_range(0, 9) != 0);
      i_flags_hit = 1'($urandom);
      i_ram_ready = ($urandom_range(0, 3) != 0);
      i_io_ready  = ($urandom_range(0, 3) != 0);
      rst_n       = ($urandom_range(0, 99) != 0);
      i_gpr_a = 8'($urandom); i_gpr_b = 8'($urandom); i_ram = 8'($urandom);
      i_acc   = 8'($urandom); i_iar   = 8'($urandom); i_io  = 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_bus_sequencer.md
Name: cpu_bus_sequencer

Overview:
- Next-generation data bus for the 7-step CPU. It merges the stepper and the bus router into one clocked block.
- A one-hot step ring counter drives a combinational source mux onto `o_bus`. It also generates per-step destination write enables.
- Generalised over data width, GPR count and step count.
- Adds ready/wait handshakes for RAM and IO, plus an instruction-done strobe.
- Sits between the register file, ALU, RAM and IO ports and the CPU top level. It replaces the hand-wired step/instr routing.

Parameters:
- `DATA_W`, 8: bus/register width. Must satisfy `DATA_W >= 4 + 2*RW`.
- `GPR_N`, 4: number of GPRs. `RW = clog2(GPR_N)`, minimum 1.
- `STEPS`, 6: steps per instruction, minimum 6. Steps 7..STEPS are idle.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous reset, active low
- `i_run`  in  1  1 = sequencer advances; 0 = freeze step, all enables 0
- `i_ir`  in  `DATA_W`  instruction register
  - opcode = `[DATA_W-1:DATA_W-4]`
  - regA = `[2*RW-1:RW]`, regB = `[RW-1:0]`
  - io_out = `[DATA_W-5]`
- `i_flags_hit`  in  1  jump-if condition true
- `i_ram_ready`  in  1  RAM read data valid
- `i_io_ready`  in  1  IO device ready
- `i_gpr_a`, `i_gpr_b`, `i_ram`, `i_acc`, `i_iar`, `i_io`  in  `DATA_W`  bus sources
- `o_gpr_a_sel`, `o_gpr_b_sel`  out  `RW`  GPR read selects (= regA, regB)
- `o_gpr_wsel`  out  `RW`  GPR write select (= regB)
- `o_step`  out  `STEPS`  one-hot step; bit0 = step 1
- `o_bus`  out  `DATA_W`  bus value; 0 when no source is driving
- `o_ir_we`, `o_iar_we`, `o_mar_we`, `o_tmp_we`, `o_acc_we`, `o_gpr_we`, `o_ram_we`, `o_io_we`  out  1  destination write enables
- `o_bus1`  out  1  ALU forced +1 (IAR increment)
- `o_alu_go`  out  1  ALU operation uses `i_ir` op bits
- `o_instr_done`  out  1  one-cycle pulse on the final-step advance

Behaviour:
- Reset: `rst_n=0` at a clock edge sets `o_step` to step 1 and `o_instr_done` to 0. All enables are 0 while `rst_n=0`. Reset mid-instruction abandons the instruction, with no partial writes after the edge.
- Advance: `adv = i_run & !wait`. On `adv`, the step rotates left; the final step wraps to step 1. Otherwise the step holds.
- Wait conditions, each asserted only in its step:
  - `wait = !i_ram_ready` in step 2.
  - `wait = !i_ram_ready` in step 5 of LD, DATA and JMP.
  - `wait = !i_ram_ready` in step 6 of JMPIF when `i_flags_hit`.
  - `wait = !i_io_ready` in step 4 of IO.
- `o_bus` and `o_bus1` follow the current step whenever `i_run=1`, including during wait.
- All `*_we` and `o_alu_go` are qualified by `adv`. Each transfer captures exactly once.
- Fetch steps:
  - Step 1: IAR -> MAR, `bus1`, `acc_we`.
  - Step 2: RAM -> IR.
  - Step 3: ACC -> IAR.
- ALU (`1xxx`):
  - Step 4: B -> TMP.
  - Step 5: A -> bus, `alu_go`, `acc_we`.
  - Step 6: ACC -> GPR[regB], suppressed for CMP (`1111`).
- LD (`0000`): step 4 A -> MAR; step 5 RAM -> GPR[regB].
- ST (`0001`): step 4 A -> MAR; step 5 B -> RAM.
- DATA (`0010`): step 4 IAR -> MAR, `bus1`, `acc_we`; step 5 RAM -> GPR[regB]; step 6 ACC -> IAR.
- JMPR (`0011`): step 4 B -> IAR.
- JMP (`0100`): step 4 IAR -> MAR; step 5 RAM -> IAR.
- JMPIF (`0101`):
  - Step 4: IAR -> MAR, `bus1`, `acc_we`.
  - Step 5: ACC -> IAR.
  - Step 6: RAM -> IAR only if `i_flags_hit`, sampled in step 6.
- CLF (`0110`): no bus activity.
- IO (`0111`): step 4 with `io_out=1` drives B -> IO (`io_we`); with `io_out=0` drives IO -> GPR[regB].
- Steps not listed: `o_bus=0`, no enables.
- `o_instr_done=1` in the cycle where the final step has `adv=1`.
- `i_run` low mid-instruction freezes the step and resumes in place.

Optional Feature:
- Macro: `CPU_BUS_STEP_SKIP_EN`.
- Defined: after the last active step of the current opcode, `adv` returns to step 1 and pulses `o_instr_done`. Last active steps:
  - step 4 for JMPR and IO;
  - step 5 for LD, ST and JMP;
  - step 3 for CLF;
  - step 5 for JMPIF when `!i_flags_hit`.
- Not defined: every instruction always takes all `STEPS` steps.

Test Plan:
- Reset with `rst_n=0` for 2 clocks, then `i_run=1`: `o_step=6'b000001`, all enables 0, `o_instr_done=0`.
- Fetch of ADD (`i_ir=8'h86`, `i_iar=8'h55`, `i_ram=8'haa`):
  - step 1: `o_bus=8'h55` with `mar_we`, `bus1`, `acc_we`;
  - step 2: `o_bus=8'haa` with `ir_we`;
  - step 4: `o_bus=i_gpr_b` with `tmp_we`;
  - step 6: `gpr_we` with `o_gpr_wsel=2`;
  - `o_instr_done` at step 6.
- CMP `8'hF6`: step 6 gives `gpr_we=0`. LD with `i_ram_ready=0` for 3 cycles in step 5: step held, `o_bus=i_ram`, `gpr_we=0` until the ready cycle, then exactly one `gpr_we` pulse.
- JMPIF `8'h50` with `i_flags_hit=0`: step 6 has no `iar_we`. Same with `i_flags_hit=1`, `i_ram=8'h3c`: step 6 gives `o_bus=8'h3c`, `iar_we=1`.
- IO out `8'h7B` (B=3, `i_gpr_b=8'hff`) with `i_io_ready` low 2 cycles: `o_bus=8'hff`, single `io_we` when ready. IO in `8'h73`, `i_io=8'hdd`: `gpr_we` with bus `8'hdd`.
- Reset asserted at step 5 of ST: no `ram_we` after the edge, next step is step 1. With `CPU_BUS_STEP_SKIP_EN`, JMPR pulses `o_instr_done` at step 4 and the next cycle is step 1.
